// File: rtl/memctrl_burst.sv
// Byte-serial main-memory controller: arbitrates IF/MEM word requests (MEM wins) and
// replays them as single-byte RAM accesses, returning little-endian words with a done pulse.
module memctrl_burst #(
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_BYTES  = 4,
   parameter int LEN_WIDTH  = $clog2(MAX_BYTES) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_req_in,
   input  logic [ADDR_WIDTH-1:0]   if_addr_in,
   input  logic                    if_flush_in,
   output logic                    if_done_o,
   output logic [8*MAX_BYTES-1:0]  if_data_o,
   input  logic                    mem_req_in,
   input  logic                    mem_we_in,
   input  logic [ADDR_WIDTH-1:0]   mem_addr_in,
   input  logic [LEN_WIDTH-1:0]    mem_len_in,
   input  logic [8*MAX_BYTES-1:0]  mem_data_in,
   output logic                    mem_done_o,
   output logic [8*MAX_BYTES-1:0]  mem_data_o,
   output logic                    busy_o,
   input  logic [7:0]              ram_din_i,
   output logic                    ram_we_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic [7:0]              ram_dout_o
);

   localparam int DW = 8 * MAX_BYTES;
   localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_BYTES);
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;

   function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
      logic [LEN_WIDTH-1:0] r;
      if (len == {LEN_WIDTH{1'b0}}) begin
         r = LEN_ONE;
      end else if (len > LEN_MAX) begin
         r = LEN_MAX;
      end else begin
         r = len;
      end
      return r;
   endfunction

   function automatic logic [7:0] get_byte(input logic [DW-1:0] d, input logic [LEN_WIDTH-1:0] idx);
      logic [DW-1:0] sh;
      sh = d >> {idx, 3'b000};
      return sh[7:0];
   endfunction

   state_t                  state_q, state_d;
   logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic                    we_q, we_d;
   logic                    is_if_q, is_if_d;
   logic [DW-1:0]           wdata_q, wdata_d;
   logic [DW-1:0]           rbuf_q, rbuf_d;
   logic [DW-1:0]           if_data_q, if_data_d;
   logic [DW-1:0]           mem_data_q, mem_data_d;
   logic                    if_done_q, if_done_d;
   logic                    mem_done_q, mem_done_d;
   logic                    busy_q, busy_d;
   logic                    ram_we_q, ram_we_d;
   logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
   logic [7:0]              ram_dout_q, ram_dout_d;

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      base_d     = base_q;
      we_d       = we_q;
      is_if_d    = is_if_q;
      wdata_d    = wdata_q;
      rbuf_d     = rbuf_q;
      if_data_d  = if_data_q;
      mem_data_d = mem_data_q;
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      ram_we_d   = 1'b0;
      ram_addr_d = {ADDR_WIDTH{1'b0}};
      ram_dout_d = 8'h00;

      case (state_q)
         ST_IDLE: begin
            if (mem_req_in) begin
               is_if_d = 1'b0;
               we_d    = mem_we_in;
               base_d  = mem_addr_in;
               len_d   = clamp_len(mem_len_in);
               wdata_d = mem_data_in;
               cnt_d   = {LEN_WIDTH{1'b0}};
               rbuf_d  = {DW{1'b0}};
               state_d = mem_we_in ? ST_WRITE : ST_READ;
            end else if (if_req_in) begin
               is_if_d = 1'b1;
               we_d    = 1'b0;
               base_d  = if_addr_in;
               len_d   = LEN_MAX;
               wdata_d = {DW{1'b0}};
               cnt_d   = {LEN_WIDTH{1'b0}};
               rbuf_d  = {DW{1'b0}};
               state_d = ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (is_if_q && if_flush_in) begin
               state_d = ST_IDLE;
            end else begin
               // byte cnt-1 arrives one cycle after its address; buffer was zeroed at grant
               if (cnt_q != {LEN_WIDTH{1'b0}}) begin
                  rbuf_d = rbuf_q | (DW'(ram_din_i) << {cnt_q - LEN_ONE, 3'b000});
               end else begin
                  rbuf_d = rbuf_q;
               end
               if (cnt_q == len_q) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q + LEN_ONE;
               end
            end
         end
         ST_WRITE: begin
            if (cnt_q == len_q - LEN_ONE) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + LEN_ONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (state_d == ST_DONE) begin
         if_done_d  = is_if_q;
         mem_done_d = !is_if_q;
         if (!we_q && is_if_q) begin
            if_data_d = rbuf_d;
         end else if (!we_q) begin
            mem_data_d = rbuf_d;
         end else begin
            mem_data_d = mem_data_q;
         end
      end else begin
         if_done_d = 1'b0;
      end

      // RAM port is registered, so it is decoded from next-cycle state and count
      if (state_d == ST_READ && cnt_d < len_d) begin
         ram_addr_d = base_d + ADDR_WIDTH'(cnt_d);
      end else if (state_d == ST_WRITE) begin
         ram_we_d   = 1'b1;
         ram_addr_d = base_d + ADDR_WIDTH'(cnt_d);
         ram_dout_d = get_byte(wdata_d, cnt_d);
      end else begin
         ram_we_d = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= {LEN_WIDTH{1'b0}};
         len_q      <= {LEN_WIDTH{1'b0}};
         base_q     <= {ADDR_WIDTH{1'b0}};
         we_q       <= 1'b0;
         is_if_q    <= 1'b0;
         wdata_q    <= {DW{1'b0}};
         rbuf_q     <= {DW{1'b0}};
         if_data_q  <= {DW{1'b0}};
         mem_data_q <= {DW{1'b0}};
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         busy_q     <= 1'b0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= {ADDR_WIDTH{1'b0}};
         ram_dout_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         base_q     <= base_d;
         we_q       <= we_d;
         is_if_q    <= is_if_d;
         wdata_q    <= wdata_d;
         rbuf_q     <= rbuf_d;
         if_data_q  <= if_data_d;
         mem_data_q <= mem_data_d;
         if_done_q  <= if_done_d;
         mem_done_q <= mem_done_d;
         busy_q     <= busy_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_dout_q <= ram_dout_d;
      end
   end

   assign if_done_o  = if_done_q;
   assign if_data_o  = if_data_q;
   assign mem_done_o = mem_done_q;
   assign mem_data_o = mem_data_q;
   assign busy_o     = busy_q;
   assign ram_we_o   = ram_we_q;
   assign ram_addr_o = ram_addr_q;
   assign ram_dout_o = ram_dout_q;

endmodule

// File: tb/tb_memctrl_burst.sv
// Scoreboard bench for memctrl_burst: per-cycle expected RAM-port/status trace and
// expected result words are queued with the stimulus and compared as the DUT produces them.
module tb_memctrl_burst;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_in, if_flush_in, mem_req_in, mem_we_in;
   logic [31:0] if_addr_in, mem_addr_in;
   logic [2:0]  mem_len_in;
   logic [31:0] mem_data_in;
   logic        if_done_o, mem_done_o, busy_o, ram_we_o;
   logic [31:0] if_data_o, mem_data_o, ram_addr_o;
   logic [7:0]  ram_din_i, ram_dout_o;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [7:0]  dout;
      logic [2:0]  fl;   // {busy, if_done, mem_done}
   } cyc_t;

   cyc_t        exp_q[$];
   logic [31:0] if_word_q[$];
   logic [31:0] mem_word_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   memctrl_burst #(.ADDR_WIDTH(32), .MAX_BYTES(4)) dut (
      .clk(clk), .rst(rst),
      .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_flush_in(if_flush_in),
      .if_done_o(if_done_o), .if_data_o(if_data_o),
      .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_addr_in(mem_addr_in),
      .mem_len_in(mem_len_in), .mem_data_in(mem_data_in),
      .mem_done_o(mem_done_o), .mem_data_o(mem_data_o), .busy_o(busy_o),
      .ram_din_i(ram_din_i), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
      .ram_dout_o(ram_dout_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom(input logic [31:0] a);
      logic [7:0] r;
      case (a)
         32'h100: r = 8'h13;
         32'h101: r = 8'h05;
         32'h102: r = 8'h00;
         32'h103: r = 8'h00;
         32'h030: r = 8'hFF;
         32'h040: r = 8'h11;
         32'h041: r = 8'h22;
         32'h042: r = 8'h33;
         32'h043: r = 8'h44;
         default: r = a[7:0] ^ 8'h5A;
      endcase
      return r;
   endfunction

   // RAM read port: data for the presented address one cycle later
   always @(posedge clk) ram_din_i <= rom(ram_addr_o);

   function automatic cyc_t cur();
      cyc_t c;
      c.we   = ram_we_o;
      c.addr = ram_addr_o;
      c.dout = ram_dout_o;
      c.fl   = {busy_o, if_done_o, mem_done_o};
      return c;
   endfunction

   task automatic push(input logic we, input logic [31:0] a, input logic [7:0] d, input logic [2:0] fl);
      cyc_t c;
      c.we = we; c.addr = a; c.dout = d; c.fl = fl;
      exp_q.push_back(c);
   endtask

   task automatic test_reset();
      #12;
      vectors++;
      if ({ram_we_o, ram_addr_o, ram_dout_o, busy_o, if_done_o, mem_done_o, if_data_o, mem_data_o} !== 108'h0) begin
         miscompares++;
         $display("FAIL reset_state: got we=%b addr=%h dout=%h busy=%b ifd=%b memd=%b ifdata=%h memdata=%h, expected all 0",
                  ram_we_o, ram_addr_o, ram_dout_o, busy_o, if_done_o, mem_done_o, if_data_o, mem_data_o);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_if_fetch();
      cyc_t e;
      logic [31:0] w;
      push(1'b0, 32'h0, 8'h00, 3'b000);
      for (int k = 0; k < 4; k++) push(1'b0, 32'h100 + k, 8'h00, 3'b100);
      push(1'b0, 32'h0, 8'h00, 3'b100);
      push(1'b0, 32'h0, 8'h00, 3'b110);
      push(1'b0, 32'h0, 8'h00, 3'b000);
      if_word_q.push_back(32'h0000_0513);
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if_req_in  = (c == 0);
         if_addr_in = 32'h100;
         @(negedge clk);
         e = exp_q.pop_front();
         vectors++;
         if (cur() !== e) begin
            miscompares++;
            $display("FAIL if_fetch cycle %0d: got %h expected %h", c, cur(), e);
         end
         if (c == 6) begin
            w = if_word_q.pop_front();
            vectors++;
            if (if_data_o !== w) begin
               miscompares++;
               $display("FAIL if_fetch_data: got %h expected %h", if_data_o, w);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      cyc_t e;
      logic [31:0] w;
      push(1'b0, 32'h0, 8'h00, 3'b000);
      push(1'b1, 32'h20, 8'hEF, 3'b100);
      push(1'b1, 32'h21, 8'hBE, 3'b100);
      push(1'b0, 32'h0, 8'h00, 3'b101);
      push(1'b0, 32'h0, 8'h00, 3'b000);
      for (int k = 0; k < 4; k++) push(1'b0, 32'h40 + k, 8'h00, 3'b100);
      push(1'b0, 32'h0, 8'h00, 3'b100);
      push(1'b0, 32'h0, 8'h00, 3'b110);
      push(1'b0, 32'h0, 8'h00, 3'b000);
      if_word_q.push_back(32'h4433_2211);
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            if_req_in = 1'b1; if_addr_in = 32'h40;
            mem_req_in = 1'b1; mem_we_in = 1'b1; mem_addr_in = 32'h20;
            mem_len_in = 3'd2; mem_data_in = 32'h0000_BEEF;
         end
         if (c == 1) mem_req_in = 1'b0;
         if (c == 5) if_req_in = 1'b0;
         @(negedge clk);
         e = exp_q.pop_front();
         vectors++;
         if (cur() !== e) begin
            miscompares++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h", c, cur(), e);
         end
         if (c == 3) begin
            vectors++;
            if (mem_data_o !== 32'h0) begin
               miscompares++;
               $display("FAIL write_keeps_mem_data: got %h expected %h", mem_data_o, 32'h0);
            end
         end
         if (c == 10) begin
            w = if_word_q.pop_front();
            vectors++;
            if (if_data_o !== w) begin
               miscompares++;
               $display("FAIL if_after_mem_data: got %h expected %h", if_data_o, w);
            end
         end
      end
   endtask

   task automatic test_mem_read();
      cyc_t        e;
      logic [31:0] w;
      logic [31:0] addrs [4] = '{32'h30, 32'h100, 32'h100, 32'h100};
      logic [2:0]  lens  [4] = '{3'd1, 3'd0, 3'd7, 3'd2};
      int          nb    [4] = '{1, 1, 4, 2};
      logic [31:0] words [4] = '{32'h0000_00FF, 32'h0000_0013, 32'h0000_0513, 32'h0000_0513};
      for (int i = 0; i < 4; i++) begin
         push(1'b0, 32'h0, 8'h00, 3'b000);
         for (int k = 0; k < nb[i]; k++) push(1'b0, addrs[i] + k, 8'h00, 3'b100);
         push(1'b0, 32'h0, 8'h00, 3'b100);
         push(1'b0, 32'h0, 8'h00, 3'b101);
         mem_word_q.push_back(words[i]);
         for (int c = 0; c < nb[i] + 3; c++) begin
            @(posedge clk); #1;
            mem_req_in  = (c == 0);
            mem_we_in   = 1'b0;
            mem_addr_in = addrs[i];
            mem_len_in  = lens[i];
            mem_data_in = 32'hDEAD_BEEF;
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (cur() !== e) begin
               miscompares++;
               $display("FAIL mem_read%0d cycle %0d: got %h expected %h", i, c, cur(), e);
            end
         end
         w = mem_word_q.pop_front();
         vectors++;
         if (mem_data_o !== w || if_data_o !== 32'h4433_2211) begin
            miscompares++;
            $display("FAIL mem_read%0d_data: got mem %h if %h expected mem %h if %h",
                     i, mem_data_o, if_data_o, w, 32'h4433_2211);
         end
      end
   endtask

   task automatic test_addr_wrap();
      cyc_t e;
      logic [31:0] d = 32'hA1B2_C3D4;
      push(1'b0, 32'h0, 8'h00, 3'b000);
      for (int k = 0; k < 4; k++) push(1'b1, 32'hFFFF_FFFE + k, d[8*k +: 8], 3'b100);
      push(1'b0, 32'h0, 8'h00, 3'b101);
      push(1'b0, 32'h0, 8'h00, 3'b000);
      for (int c = 0; c < 7; c++) begin
         @(posedge clk); #1;
         mem_req_in  = (c == 0);
         mem_we_in   = 1'b1;
         mem_addr_in = 32'hFFFF_FFFE;
         mem_len_in  = 3'd4;
         mem_data_in = d;
         @(negedge clk);
         e = exp_q.pop_front();
         vectors++;
         if (cur() !== e) begin
            miscompares++;
            $display("FAIL addr_wrap cycle %0d: got %h expected %h", c, cur(), e);
         end
      end
   endtask

   task automatic test_flush();
      cyc_t e;
      logic [31:0] w;
      push(1'b0, 32'h0, 8'h00, 3'b000);
      for (int k = 0; k < 3; k++) push(1'b0, 32'h200 + k, 8'h00, 3'b100);
      push(1'b0, 32'h0, 8'h00, 3'b000);
      push(1'b0, 32'h30, 8'h00, 3'b100);
      push(1'b0, 32'h0, 8'h00, 3'b100);
      push(1'b0, 32'h0, 8'h00, 3'b101);
      push(1'b0, 32'h0, 8'h00, 3'b000);
      mem_word_q.push_back(32'h0000_00FF);
      for (int c = 0; c < 9; c++) begin
         @(posedge clk); #1;
         if_req_in  = (c == 0);
         if_addr_in = 32'h200;
         if_flush_in = (c == 3);
         if (c == 3) begin
            mem_req_in = 1'b1; mem_we_in = 1'b0; mem_addr_in = 32'h30; mem_len_in = 3'd1;
         end
         if (c == 5) mem_req_in = 1'b0;
         @(negedge clk);
         e = exp_q.pop_front();
         vectors++;
         if (cur() !== e) begin
            miscompares++;
            $display("FAIL flush cycle %0d: got %h expected %h", c, cur(), e);
         end
         if (c == 7) begin
            w = mem_word_q.pop_front();
            vectors++;
            if (mem_data_o !== w || if_data_o !== 32'h4433_2211) begin
               miscompares++;
               $display("FAIL flush_data: got mem %h if %h expected mem %h if %h",
                        mem_data_o, if_data_o, w, 32'h4433_2211);
            end
         end
      end
   endtask

   task automatic test_reset_mid_write();
      cyc_t e;
      push(1'b0, 32'h0, 8'h00, 3'b000);
      push(1'b1, 32'h50, 8'h04, 3'b100);
      push(1'b1, 32'h51, 8'h03, 3'b100);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         mem_req_in  = (c == 0);
         mem_we_in   = 1'b1;
         mem_addr_in = 32'h50;
         mem_len_in  = 3'd4;
         mem_data_in = 32'h0102_0304;
         if (c < 2) @(negedge clk);
         e = exp_q.pop_front();
         vectors++;
         if (cur() !== e) begin
            miscompares++;
            $display("FAIL rst_mid_write cycle %0d: got %h expected %h", c, cur(), e);
         end
      end
      #1 rst = 1'b1;
      #1;
      vectors++;
      if ({ram_we_o, ram_addr_o, busy_o, if_data_o, mem_data_o} !== 98'h0) begin
         miscompares++;
         $display("FAIL async_reset: got we=%b addr=%h busy=%b ifdata=%h memdata=%h expected all 0",
                  ram_we_o, ram_addr_o, busy_o, if_data_o, mem_data_o);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         push(1'b0, 32'h0, 8'h00, 3'b000);
         @(negedge clk);
         e = exp_q.pop_front();
         vectors++;
         if (cur() !== e) begin
            miscompares++;
            $display("FAIL after_reset cycle %0d: got %h expected %h", c, cur(), e);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      if_req_in = 1'b0; if_addr_in = 32'h0; if_flush_in = 1'b0;
      mem_req_in = 1'b0; mem_we_in = 1'b0; mem_addr_in = 32'h0;
      mem_len_in = 3'd0; mem_data_in = 32'h0;
      test_reset();
      test_if_fetch();
      test_back_to_back();
      test_mem_read();
      test_addr_wrap();
      test_flush();
      test_reset_mid_write();
      vectors++;
      if (exp_q.size() + if_word_q.size() + mem_word_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0",
                  exp_q.size() + if_word_q.size() + mem_word_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
